// File: rtl/rv_mem.sv
// rv_mem: memory-access pipeline stage.
// Performs RV32I loads and stores over a req/ack data-memory port and stalls
// the upstream stage while an access is in flight. Results are registered
// into mem_wb_* for the write-back stage.
module rv_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_mem_ir,
  input  logic [31:0] ex_mem_alu_out,
  input  logic [31:0] ex_mem_rs2,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mem_wb_ir,
  output logic [31:0] mem_wb_data,
  output logic        mem_wb_exc
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  a;
  logic        is_load;
  logic        is_store;
  logic        f3_ok;
  logic        misalign;
  logic        fault;
  logic        valid_mem;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Decode the instruction currently offered by EX; upstream holds it stable
  // for the whole access, so REQ can keep using it for data extraction.
  always_comb begin
    opcode   = ex_mem_ir[6:0];
    funct3   = ex_mem_ir[14:12];
    a        = ex_mem_alu_out[1:0];
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    f3_ok    = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   misalign = a[0];
      2'b10:   misalign = (a != 2'b00);
      default: misalign = 1'b0;
    endcase
    fault     = (is_load || is_store) && (!f3_ok || misalign);
    valid_mem = (is_load || is_store) && !fault;
  end

  // Store lane placement; loads always read the full word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << a;
          wdata_next = {4{ex_mem_rs2[7:0]}};
        end
        2'b01: begin
          be_next    = a[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{ex_mem_rs2[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = ex_mem_rs2;
        end
      endcase
    end
  end

  // Load data extraction and sign/zero extension from the returned word.
  always_comb begin
    shifted  = dmem_rdata >> {a, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Stall is combinational so EX advances on the same edge the access retires.
  always_comb begin
    if (state == IDLE) mem_stall = valid_mem;
    else               mem_stall = !dmem_ack;
  end

  // Access FSM with registered bus and write-back outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      mem_wb_ir   <= 32'h0;
      mem_wb_data <= 32'h0;
      mem_wb_exc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_mem) begin
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= {ex_mem_alu_out[31:2], 2'b00};
            dmem_be     <= be_next;
            dmem_wdata  <= wdata_next;
            mem_wb_ir   <= 32'h0;
            mem_wb_data <= 32'h0;
            mem_wb_exc  <= 1'b0;
            state       <= REQ;
          end else begin
            mem_wb_ir   <= ex_mem_ir;
            mem_wb_data <= fault ? 32'h0 : ex_mem_alu_out;
            mem_wb_exc  <= fault;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            mem_wb_ir   <= ex_mem_ir;
            mem_wb_exc  <= 1'b0;
            mem_wb_data <= is_load ? load_data : 32'h0;
            state       <= IDLE;
          end else begin
            mem_wb_ir   <= 32'h0;
            mem_wb_data <= 32'h0;
            mem_wb_exc  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv_mem.md
# rv_mem

Memory-access (MEM) pipeline stage. It sits directly downstream of the EX stage and consumes `ex_mem_ir`, `ex_mem_alu_out` and `ex_mem_rs2`. It performs RV32I loads and stores over a req/ack data-memory port, and stalls the upstream pipeline while an access is outstanding. Results go to the WB stage through registered `mem_wb_*` outputs.

## Interface
No parameters.
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ex_mem_ir`  in  32  instruction from EX; opcode = [6:0], funct3 = [14:12]
- `ex_mem_alu_out`  in  32  ALU result; effective address for loads/stores
- `ex_mem_rs2`  in  32  store data source
- `mem_stall`  out  1  combinational; 1 = upstream must hold `ex_mem_*` stable and not advance
- `dmem_req`  out  1  access request, registered
- `dmem_we`  out  1  1 = write, 0 = read
- `dmem_addr`  out  32  word address {addr[31:2], 2'b00}
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_rdata`  in  32  read data, valid in the cycle `dmem_ack`=1
- `dmem_ack`  in  1  access complete; single-cycle pulse
- `mem_wb_ir`  out  32  instruction to WB; 32'b0 = bubble
- `mem_wb_data`  out  32  load result or pass-through ALU result
- `mem_wb_exc`  out  1  misaligned address or unsupported funct3 on a load/store

## Operation
- Instruction classes:
  - LOAD: opcode 7'b0000011, funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - STORE: opcode 7'b0100011, funct3 ∈ {000 SB, 001 SH, 010 SW}.
  - Every other opcode is pass-through.
- Fault condition:
  - A LOAD/STORE with any other funct3 faults.
  - Halfword ops fault when addr[0]=1; word ops fault when addr[1:0]≠00.
  - A fault causes no bus access; completes in 1 cycle with `mem_wb_exc`=1 and `mem_wb_data`=0.
- FSM states:
  - IDLE: if `ex_mem_ir` is a valid (non-faulting) load/store:
    - assert `mem_stall`
    - at the edge, latch `dmem_addr`/`dmem_we`/`dmem_be`/`dmem_wdata`, set `dmem_req`=1, go to REQ
    - `mem_wb_ir`←0 (bubble)
  - IDLE, otherwise: register `mem_wb_ir`←`ex_mem_ir`, `mem_wb_data`←`ex_mem_alu_out` (or 0 on fault), `mem_wb_exc` accordingly.
  - REQ: hold all `dmem_*` outputs stable.
    - `mem_stall` = !`dmem_ack`.
    - `dmem_ack`=0: `mem_wb_ir`←0.
    - `dmem_ack`=1: `dmem_req`←0, `mem_wb_ir`←`ex_mem_ir`, `mem_wb_exc`←0, `mem_wb_data`←extracted load data (stores: 0); go to IDLE.
- Store lanes (a = addr[1:0]):
  - SB: be = 4'b0001<<a, wdata = {4{rs2[7:0]}}
  - SH: be = a[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}
  - SW: be = 1111, wdata = rs2
- Loads: be = 1111, we = 0, wdata = 0.
  - Byte: select rdata[8a+7:8a].
  - Half: select rdata[16a[1]+15:16a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `mem_wb_ir`, `mem_wb_data`, `mem_wb_exc` all 0. `mem_stall` is then a function of the inputs only.
- Reset during REQ: `dmem_req` drops immediately and the access is abandoned. An ack arriving after release is ignored.
- Latency:
  - pass-through or fault: 1 cycle
  - load/store: 2 + N cycles, where N = wait cycles before `dmem_ack`
- `mem_stall` deasserts in the same cycle `dmem_ack`=1. The EX stage therefore advances on the same edge the access retires, and back-to-back memory ops need no idle gap.
- Exactly one non-bubble `mem_wb_ir` is produced per instruction. Stall cycles always emit bubbles.

## Test plan
- Reset: drive `rst`=0 mid-REQ with `dmem_req`=1 → `dmem_req`=0 immediately, all `mem_wb_*`=0; after release, state is IDLE and a stray `dmem_ack` is ignored.
- Pass-through: ADD instruction, alu_out=32'h0000_1234 → next edge `mem_wb_ir`=instruction, `mem_wb_data`=32'h1234, `mem_stall`=0, no `dmem_req`.
- LB, addr 32'h0000_0103, rdata=32'h80AA_BBCC, ack after 2 wait cycles:
  - `dmem_addr`=32'h100, be=1111
  - `mem_stall` high for 3 cycles, bubbles emitted meanwhile
  - `mem_wb_data`=32'hFFFF_FF80
- SH, addr 32'h202, rs2=32'hDEAD_BEEF, ack in first REQ cycle → we=1, be=1100, wdata=32'hBEEF_BEEF, `dmem_addr`=32'h200, total 2 cycles.
- LW at addr 32'h0000_0006 → no `dmem_req`, 1-cycle retire with `mem_wb_exc`=1, `mem_wb_data`=0. Same for funct3=011 on LOAD.
- Back-to-back SW, then LBU (addr 1, rdata=32'h0000_F100, ack immediate each) → two accesses with no idle gap between them, LBU result=32'h0000_00F1.
